rx_iq_byte_packer: RTL and testbench

//   Downstream of the receiver chain: captures each strobed 24-bit I/Q sample pair,

---
 rtl/rx_iq_byte_packer.sv | 136 +++++++++++++
 tb/tb_rx_iq_byte_packer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_iq_byte_packer.sv
// rx_iq_byte_packer
//   Captures strobed 24-bit I/Q sample pairs into a small FIFO and serialises
//   each pair MSB-first as six bytes: I[23:16], I[15:8], I[7:0], Q[23:16],
//   Q[15:8], Q[7:0]. Samples arriving while the FIFO is full are dropped and
//   counted in a saturating 16-bit counter.
//
// Handshake: a byte transfers on a rising clock edge where out_valid and
//   out_ready are both high. Once out_valid is raised, it stays high, and
//   out_data stays stable, until that transfer happens. out_ready may change
//   freely and never affects out_valid combinationally.
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   in_strobe      in   in_I/in_Q are valid this cycle
//   in_I, in_Q     in   24-bit signed samples
//   out_data       out  current byte
//   out_valid      out  out_data is valid
//   out_ready      in   consumer accepts the byte
//   fifo_level     out  sample pairs held in the FIFO (0..DEPTH)
//   overflow_count out  dropped samples, saturating at 16'hFFFF
//   state_dbg      out  serialiser state (0 = IDLE, 1 = SEND)
module rx_iq_byte_packer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_strobe,
  input  logic [23:0]   in_I,
  input  logic [23:0]   in_Q,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   fifo_level,
  output logic [15:0]   overflow_count,
  output logic          state_dbg
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  state_t      state, state_nxt;
  logic [47:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [47:0] word;
  logic [2:0]  idx, idx_nxt;
  logic        full, empty, wr_en, pop;

  // Pointers carry one extra wrap bit, so their difference is the level.
  assign fifo_level = wr_ptr - rd_ptr;
  assign empty      = (fifo_level == '0);
  // Fullness is judged before any same-cycle pop, so a pop never frees a
  // slot for a write in the same cycle.
  assign full       = (fifo_level == LEVEL_FULL);
  assign wr_en      = in_strobe && !full;

  // FIFO storage; no reset needed, contents are qualified by the pointers.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {in_I, in_Q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      overflow_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (in_strobe && full && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;
    end
  end

  // Serialiser: state, byte index and the word currently being sent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      word  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (pop) word <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          idx_nxt   = 3'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx != 3'd5) begin
            idx_nxt = idx + 3'd1;
          end else if (!empty) begin
            // Back-to-back pairs: load the next word with no idle cycle.
            pop     = 1'b1;
            idx_nxt = 3'd0;
          end else begin
            idx_nxt   = 3'd0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == SEND);
  assign state_dbg = state;

  always_comb begin
    out_data = 8'h00;
    case (idx)
      3'd0:    out_data = word[47:40];
      3'd1:    out_data = word[39:32];
      3'd2:    out_data = word[31:24];
      3'd3:    out_data = word[23:16];
      3'd4:    out_data = word[15:8];
      3'd5:    out_data = word[7:0];
      default: out_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_rx_iq_byte_packer.sv
module tb_rx_iq_byte_packer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_strobe = 1'b0;
  logic [23:0] in_i = '0;
  logic [23:0] in_q = '0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [AW:0] fifo_level;
  logic [15:0] overflow_count;
  logic        state_dbg;

  always #5 clock = ~clock;

  rx_iq_byte_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset), .in_strobe(in_strobe),
    .in_I(in_i), .in_Q(in_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level),
    .overflow_count(overflow_count), .state_dbg(state_dbg)
  );

  // ---------------- check / counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sample pairs waiting, the pair being sent and how many bytes of it are gone.
  logic [47:0] fq[$];
  bit          m_busy;
  logic [47:0] m_word;
  int          m_sent;
  int          m_drops;
  // Scoreboard: every byte the stream must carry, in order.
  logic [7:0]  exp_q[$];
  int          hs_count;

  function automatic logic [7:0] byte_of(input logic [47:0] w, input int k);
    return 8'((w >> (8 * (5 - k))) & 48'hFF);
  endfunction

  task automatic model_clear();
    fq.delete();
    exp_q.delete();
    m_busy  = 0;
    m_word  = '0;
    m_sent  = 0;
    m_drops = 0;
  endtask

  // One clock edge of the reference behaviour, from the inputs held at that edge.
  task automatic model_edge();
    bit was_full;
    bit take;
    was_full = (fq.size() == DEPTH);
    take = 0;
    if (!m_busy) begin
      take = (fq.size() > 0);
    end else if (out_ready) begin
      if (m_sent < 5) m_sent++;
      else if (fq.size() > 0) take = 1;
      else m_busy = 0;
    end
    if (take) begin
      m_word = fq.pop_front();
      m_sent = 0;
      m_busy = 1;
    end
    if (in_strobe) begin
      if (!was_full) begin
        fq.push_back({in_i, in_q});
        for (int k = 0; k < 6; k++) exp_q.push_back(byte_of({in_i, in_q}, k));
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are set before calling; outputs are sampled on the falling edge.
  task automatic step(input bit chk);
    logic [7:0] e;
    if (out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        check("sb_extra_byte", 64'(out_data), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        if (chk || out_data !== e) check("sb_byte", 64'(out_data), 64'(e));
      end
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
    if (chk) begin
      check("valid", 64'(out_valid), 64'(m_busy));
      check("level", 64'(fifo_level), 64'(fq.size()));
      check("ovf", 64'(overflow_count), 64'(m_drops));
      if (m_busy) check("data", 64'(out_data), 64'(byte_of(m_word, m_sent)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_strobe = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(overflow_count), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;
  endtask

  task automatic strobe_rand();
    in_strobe = 1'b1;
    in_i = 24'($urandom);
    in_q = 24'($urandom);
  endtask

  task automatic drain(input int budget);
    int n;
    out_ready = 1'b1;
    in_strobe = 1'b0;
    n = 0;
    while ((m_busy || exp_q.size() > 0) && n < budget) begin
      step(1);
      n++;
    end
    check("drain_timeout", 64'(n < budget), 64'd1);
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  logic [7:0] got[6];
  logic [7:0] want[6];
  int         ovf_before;

  initial begin
    model_clear();
    hs_count = 0;
    @(negedge clock);
    do_reset();

    // 1: single pair, consumer always ready.
    want[0] = 8'h12; want[1] = 8'h34; want[2] = 8'h56;
    want[3] = 8'hAB; want[4] = 8'hCD; want[5] = 8'hEF;
    out_ready = 1'b1;
    in_strobe = 1'b1; in_i = 24'h123456; in_q = 24'hABCDEF;
    step(1);
    check("t1_valid_after_1", 64'(out_valid), 64'd0);
    in_strobe = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      check("t1_valid_on", 64'(out_valid), 64'd1);
      got[k] = out_data;
    end
    for (int k = 0; k < 6; k++) check("t1_byte", 64'(got[k]), 64'(want[k]));
    step(1);
    check("t1_idle_after", 64'(out_valid), 64'd0);

    // 2: back-pressure, out_ready toggling every cycle.
    in_strobe = 1'b1; in_i = 24'h123456; in_q = 24'hABCDEF;
    out_ready = 1'b0;
    step(1);
    in_strobe = 1'b0;
    for (int c = 0; c < 14; c++) begin
      out_ready = ~out_ready;
      step(1);
    end
    drain(40);

    // 3: overflow with the consumer stalled, then drain in order.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      strobe_rand();
      step(1);
    end
    in_strobe = 1'b0;
    check("t3_level_full", 64'(fifo_level), 64'(DEPTH));
    check("t3_ovf", 64'(overflow_count), 64'd3);
    hs_count = 0;
    drain(200);
    check("t3_bytes_out", 64'(hs_count), 64'd102);

    // 4: overflow counter saturation.
    out_ready = 1'b0;
    for (int c = 0; c < 70020; c++) begin
      strobe_rand();
      step(0);
    end
    in_strobe = 1'b0;
    step(1);
    check("t4_sat", 64'(overflow_count), 64'hFFFF);
    do_reset();

    // 5a: write and pop on the same edge while full -> write dropped.
    out_ready = 1'b0;
    for (int c = 0; c < 17; c++) begin
      strobe_rand();
      step(1);
    end
    in_strobe = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) step(1);
    ovf_before = int'(overflow_count);
    strobe_rand();
    step(1);
    in_strobe = 1'b0;
    check("t5_full_level", 64'(fifo_level), 64'(DEPTH - 1));
    check("t5_full_ovf", 64'(overflow_count), 64'(ovf_before + 1));
    drain(200);

    // 5b: write and pop on the same edge at level 3 -> level unchanged.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      strobe_rand();
      step(1);
    end
    in_strobe = 1'b0;
    check("t5_level3_pre", 64'(fifo_level), 64'd3);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) step(1);
    strobe_rand();
    step(1);
    in_strobe = 1'b0;
    check("t5_level3_post", 64'(fifo_level), 64'd3);
    drain(100);

    // 6: reset in the middle of a pair, then a fresh pair.
    in_strobe = 1'b1; in_i = 24'h800001; in_q = 24'h7F00FF;
    out_ready = 1'b1;
    step(1);
    strobe_rand();
    step(1);
    in_strobe = 1'b0;
    step(1);
    step(1);
    check("t6_mid_idx", 64'(out_data), 64'h01);
    reset = 1'b1;
    #1;
    check("t6_valid_drop", 64'(out_valid), 64'd0);
    check("t6_level_drop", 64'(fifo_level), 64'd0);
    @(negedge clock);
    do_reset();
    in_strobe = 1'b1; in_i = 24'hFEDCBA; in_q = 24'h012345;
    step(1);
    in_strobe = 1'b0;
    step(1);
    check("t6_first_byte", 64'(out_data), 64'hFE);
    drain(40);

    // Random traffic and back-pressure.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) strobe_rand();
      else in_strobe = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
